// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_e        : controller states (idle, running slices, result held)
//   calc_steps     : number of DIGIT-bit slices per operation
//   step_cnt_width : width of the slice counter (at least 1 bit)
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned step_cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready   : operand transfer (a, b, bin)
//   out_valid/out_ready : result transfer (diff, bout, ovf, zero)
// master: operand source / result consumer side. slave: the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor_borrow_slice.sv
// Combinational DIGIT-bit ripple-borrow subtractor: d = x - y - bi.
//   x, y : slice of minuend / subtrahend
//   bi   : borrow into the slice LSB
//   d    : slice difference
//   bo   : borrow out of the slice MSB
module serial_subtractor_borrow_slice #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] chain;

  assign chain[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]       = x[i] ^ y[i] ^ chain[i];
    assign chain[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
  end

  assign bo = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, LSB slice first, one DIGIT-bit
// slice per clock through a registered borrow. Result and flags are held until accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result handshake bundle (slave side)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIGIT = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned STEPS = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CW    = step_cnt_width(STEPS);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({DIGIT{1'b1}});

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: need WIDTH >= 2 and DIGIT dividing WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [31:0]      slice_base;
  logic [DIGIT-1:0] slice_a, slice_b, slice_d;
  logic             slice_bo;

  // Shifts instead of variable part-selects keep the slice mux simple for any DIGIT.
  assign slice_base = 32'(step_q) * DIGIT;
  assign slice_a    = DIGIT'(a_q >> slice_base);
  assign slice_b    = DIGIT'(b_q >> slice_base);

  serial_subtractor_borrow_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x (slice_a),
    .y (slice_b),
    .bi(borrow_q),
    .d (slice_d),
    .bo(slice_bo)
  );

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          step_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        diff_d   = (diff_q & ~(SLICE_MASK << slice_base)) |
                   ((WIDTH'(slice_d) & SLICE_MASK) << slice_base);
        borrow_d = slice_bo;
        step_d   = step_q + CW'(1);
        if (step_q == CW'(STEPS - 1)) begin
          // diff_d now carries every slice, so the flags see the complete result.
          bout_d  = slice_bo;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = ~|diff_d;
          step_d  = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=4/DIGIT=1 directed vectors and corner sequences, plus
// back-to-back randomised runs on WIDTH=8 with DIGIT=2 and DIGIT=8.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8a ();
  serial_subtractor_if #(.WIDTH(8)) if8b ();

  serial_subtractor #(.WIDTH(4), .DIGIT(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut8a (.clk(clk), .rst_n(rst_n), .bus(if8a));
  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8b (.clk(clk), .rst_n(rst_n), .bus(if8b));

  // Shared driver for the two WIDTH=8 instances; sel picks which one is exercised.
  int         sel = 0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0, iv8 = 1'b0, ordy8 = 1'b0;
  assign if8a.a = a8;
  assign if8a.b = b8;
  assign if8a.bin = bin8;
  assign if8a.in_valid = iv8 && (sel == 0);
  assign if8a.out_ready = ordy8;
  assign if8b.a = a8;
  assign if8b.b = b8;
  assign if8b.bin = bin8;
  assign if8b.in_valid = iv8 && (sel == 1);
  assign if8b.out_ready = ordy8;

  logic       r_in_ready, r_out_valid, r_bout, r_ovf, r_zero;
  logic [7:0] r_diff;
  assign r_in_ready  = (sel == 0) ? if8a.in_ready  : if8b.in_ready;
  assign r_out_valid = (sel == 0) ? if8a.out_valid : if8b.out_valid;
  assign r_diff      = (sel == 0) ? if8a.diff      : if8b.diff;
  assign r_bout      = (sel == 0) ? if8a.bout      : if8b.bout;
  assign r_ovf       = (sel == 0) ? if8a.ovf       : if8b.ovf;
  assign r_zero      = (sel == 0) ? if8a.zero      : if8b.zero;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: 9-bit subtract, bit 8 is the borrow.
  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin);
    logic [8:0] full;
    logic [7:0] d;
    full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    d    = full[7:0];
    return {(d == 8'd0), ((a[7] != b[7]) && (d[7] != a[7])), full[8], d};
  endfunction

  // Present one operand set to the 4-bit DUT and return at the negedge where out_valid is seen.
  task automatic op4_run(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output int unsigned lat);
    int          guard;
    int unsigned c0;
    guard = 0;
    @(negedge clk);
    while (!if4.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", 32'(if4.in_ready), 32'd1);
    if4.a = a;
    if4.b = b;
    if4.bin = bin;
    if4.in_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    if4.in_valid = 1'b0;
    guard = 0;
    while (!if4.out_valid && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_within_bound", 32'(if4.out_valid), 32'd1);
    lat = cyc - c0 - 1;
  endtask

  task automatic op4_release();
    if4.out_ready = 1'b1;
    @(negedge clk);
    if4.out_ready = 1'b0;
    check("release_out_valid_low", 32'(if4.out_valid), 32'd0);
    check("release_in_ready_high", 32'(if4.in_ready), 32'd1);
  endtask

  task automatic run_random8(input int which, input int unsigned steps, input int n_ops);
    logic [7:0]  ca[4];
    logic [7:0]  cb[4];
    logic        cbin[4];
    logic [10:0] exp;
    logic [7:0]  ta, tb_;
    logic        tbin;
    int          guard;
    int unsigned c0, prev_c0, lat;
    ca[0] = 8'h00; cb[0] = 8'h00; cbin[0] = 1'b0;
    ca[1] = 8'hFF; cb[1] = 8'hFF; cbin[1] = 1'b1;
    ca[2] = 8'h80; cb[2] = 8'h01; cbin[2] = 1'b0;
    ca[3] = 8'h7F; cb[3] = 8'h80; cbin[3] = 1'b0;
    sel = which;
    ordy8 = 1'b1;
    prev_c0 = 0;
    for (int i = 0; i < n_ops; i++) begin
      if (i < 4) begin
        ta = ca[i]; tb_ = cb[i]; tbin = cbin[i];
      end else begin
        ta = 8'($urandom_range(0, 255));
        tb_ = 8'($urandom_range(0, 255));
        tbin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard = 0;
      while (!r_in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      check("b2b_in_ready", 32'(r_in_ready), 32'd1);
      a8 = ta;
      b8 = tb_;
      bin8 = tbin;
      iv8 = 1'b1;
      c0 = cyc;
      if (i > 0) check("b2b_period", c0 - prev_c0, steps + 2);
      prev_c0 = c0;
      @(negedge clk);
      guard = 0;
      while (!r_out_valid && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      lat = cyc - c0 - 1;
      exp = model8(ta, tb_, tbin);
      check("b2b_latency", lat, steps);
      check("b2b_diff", 32'(r_diff), 32'(exp[7:0]));
      check("b2b_bout", 32'(r_bout), 32'(exp[8]));
      check("b2b_ovf", 32'(r_ovf), 32'(exp[9]));
      check("b2b_zero", 32'(r_zero), 32'(exp[10]));
    end
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ordy8 = 1'b0;
  endtask

  initial begin
    int unsigned lat;

    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'h3, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'h9, 4'h2, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0};

    if4.in_valid = 1'b0;
    if4.out_ready = 1'b0;
    if4.a = '0;
    if4.b = '0;
    if4.bin = 1'b0;

    // Reset state
    #1;
    check("rst_in_ready", 32'(if4.in_ready), 32'd1);
    check("rst_out_valid", 32'(if4.out_valid), 32'd0);
    check("rst_diff", 32'(if4.diff), 32'd0);
    check("rst_flags", {29'd0, if4.bout, if4.ovf, if4.zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      op4_run(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      check("vec_latency", lat, 32'd4);
      check("vec_diff", 32'(if4.diff), 32'(vecs[i].diff));
      check("vec_bout", 32'(if4.bout), 32'(vecs[i].bout));
      check("vec_ovf", 32'(if4.ovf), 32'(vecs[i].ovf));
      check("vec_zero", 32'(if4.zero), 32'(vecs[i].zero));
      op4_release();
    end

    // Backpressure: hold DONE for 10 cycles while pulsing in_valid with other operands
    op4_run(4'h6, 4'h2, 1'b0, lat);
    for (int k = 0; k < 10; k++) begin
      if4.a = 4'h1;
      if4.b = 4'h1;
      if4.in_valid = (k % 2 == 0);
      @(negedge clk);
      check("hold_out_valid", 32'(if4.out_valid), 32'd1);
      check("hold_in_ready", 32'(if4.in_ready), 32'd0);
      check("hold_diff", 32'(if4.diff), 32'h4);
      check("hold_zero", 32'(if4.zero), 32'd0);
    end
    if4.in_valid = 1'b0;
    op4_release();
    check("hold_diff_after_release", 32'(if4.diff), 32'h4);

    // Reset during RUN step 2, with zero=1 held from the previous result
    op4_run(4'h3, 4'h3, 1'b0, lat);
    check("pre_reset_zero", 32'(if4.zero), 32'd1);
    op4_release();
    @(negedge clk);
    if4.a = 4'h5;
    if4.b = 4'h3;
    if4.bin = 1'b0;
    if4.in_valid = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(if4.in_ready), 32'd1);
    check("midrst_out_valid", 32'(if4.out_valid), 32'd0);
    check("midrst_diff", 32'(if4.diff), 32'd0);
    check("midrst_bout", 32'(if4.bout), 32'd0);
    check("midrst_ovf", 32'(if4.ovf), 32'd0);
    check("midrst_zero", 32'(if4.zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op4_run(4'h9, 4'h2, 1'b1, lat);
    check("postrst_latency", lat, 32'd4);
    check("postrst_diff", 32'(if4.diff), 32'h6);
    check("postrst_bout", 32'(if4.bout), 32'd0);
    check("postrst_ovf", 32'(if4.ovf), 32'd1);
    check("postrst_zero", 32'(if4.zero), 32'd0);
    op4_release();

    // Back-to-back randomised runs on the 8-bit instances
    run_random8(0, 4, 150);
    run_random8(1, 1, 150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
